// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MUL/MULHU/DIVU/REMU using a shared external ALU
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, op_i          request and operation (00 MUL, 01 MULHU, 10 DIVU, 11 REMU)
//   src_a_i, src_b_i       multiplicand/dividend, multiplier/divisor
//   flush_i                synchronous abort to IDLE, result kept
//   busy_o, done_o         operation in progress, one-cycle completion pulse
//   result_o               registered result, held between completions
//   alu_a_o, alu_b_o       ALU operands
//   alu_sel_o, alu_out_i   ALU select (0 ADD, 1 SUB) and its combinational result
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_sel_o,
    input  logic [XLEN-1:0] alu_out_i
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
    state_e state_q, state_d;
    // hi: acc (MUL) / rem (DIV); lo: mplier (MUL) / quo (DIV); b: mcand (MUL) / dvsr (DIV)
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // op[0] alone picks the result word once the MUL/DIV path is chosen
    logic            hi_sel_q, hi_sel_d;
    logic [XLEN-1:0] sum, r_lo;
    logic            carry, ge;
    // low XLEN bits of the shifted partial remainder {rem, quo[XLEN-1]}
    assign r_lo = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
            result_q <= result_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i) state_d = !op_i[1] ? MUL : (src_b_i == '0 ? DONE : DIV);
            MUL, DIV: if (cnt_q == '0) state_d = DONE;
            default:  state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
        result_d = result_q;
        sum      = lo_q[0] ? alu_out_i : hi_q;
        // a wrapped sum is smaller than acc: that is the carry out of the add
        carry    = lo_q[0] & (alu_out_i < hi_q);
        ge       = hi_q[XLEN-1] | (alu_out_i <= r_lo);
        if (!flush_i) begin
            case (state_q)
                IDLE: if (start_i) begin
                    hi_sel_d = op_i[0];
                    cnt_d    = CW'(XLEN - 1);
                    hi_d     = '0;
                    lo_d     = op_i[1] ? src_a_i : src_b_i;
                    b_d      = op_i[1] ? src_b_i : src_a_i;
                    if (op_i[1] && src_b_i == '0) result_d = op_i[0] ? src_a_i : '1;
                end
                MUL: begin
                    hi_d  = {carry, sum[XLEN-1:1]};
                    lo_d  = {sum[0], lo_q[XLEN-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) result_d = hi_sel_q ? hi_d : lo_d;
                end
                DIV: begin
                    hi_d  = ge ? alu_out_i : r_lo;
                    lo_d  = {lo_q[XLEN-2:0], ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) result_d = hi_sel_q ? hi_d : lo_d;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        busy_o    = state_q == MUL || state_q == DIV;
        done_o    = state_q == DONE;
        result_o  = result_q;
        alu_sel_o = {3'b000, state_q == DIV};
        alu_a_o   = state_q == MUL ? hi_q : (state_q == DIV ? r_lo : '0);
        alu_b_o   = busy_o ? b_q : '0;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, busy, done;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, result, alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_sel == 4'd1) ? alu_a - alu_b : alu_a + alu_b;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
        .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
        .busy_o(busy), .done_o(done), .result_o(result),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .alu_out_i(alu_out)
    );

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    // lat = cycles from accepting edge to the negedge where done is seen (0 = timeout).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output int bc,
                         output logic [3:0] sel1, output logic [31:0] b1);
        lat = 0; bc = 0;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        sel1 = alu_sel; b1 = alu_b;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bc++;
            if (done) begin lat = i; break; end
            @(negedge clk);
        end
        r = result;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if ({alu_a, alu_b, alu_sel} !== 68'h0) begin errors++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_sel); end
    endtask

    task automatic test_mul;
        logic [31:0] r, b1; logic [3:0] s1; int lat, bc;
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL mul_result got=%h exp=00000001", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end
        checks++; if (s1 !== 4'd0 || b1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_alu_drive got=%h/%h exp=0/ffffffff", s1, b1); end
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc, s1, b1);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result got=%h exp=fffffffe", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mulhu_busy_cycles got=%0d exp=32", bc); end
        do_op(2'b00, 32'h00012345, 32'h00000100, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h01234500) begin errors++; $display("FAIL mul_shift got=%h exp=01234500", r); end
    endtask

    task automatic test_div;
        logic [31:0] r, b1; logic [3:0] s1; int lat, bc;
        do_op(2'b10, 32'd100, 32'd7, r, lat, bc, s1, b1);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got=%0d exp=14", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        checks++; if (s1 !== 4'd1 || b1 !== 32'd7) begin errors++; $display("FAIL div_alu_drive got=%h/%h exp=1/7", s1, b1); end
        do_op(2'b11, 32'd100, 32'd7, r, lat, bc, s1, b1);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got=%0d exp=2", r); end
        do_op(2'b10, 32'hFFFFFFFF, 32'h1, r, lat, bc, s1, b1);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_1 got=%h exp=ffffffff", r); end
        do_op(2'b11, 32'hFFFFFFFF, 32'h1, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL remu_max_1 got=%h exp=0", r); end
        do_op(2'b10, 32'hFFFFFFFF, 32'h80000001, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL divu_bigdiv got=%h exp=1", r); end
        do_op(2'b11, 32'hFFFFFFFF, 32'h80000001, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h7FFFFFFE) begin errors++; $display("FAIL remu_bigdiv got=%h exp=7ffffffe", r); end
    endtask

    task automatic test_div_zero;
        logic [31:0] r, b1; logic [3:0] s1; int lat, bc;
        do_op(2'b10, 32'd5, 32'd0, r, lat, bc, s1, b1);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero got=%h exp=ffffffff", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu_zero_latency got=%0d exp=1", lat); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL divu_zero_busy got=%0d exp=0", bc); end
        checks++; if (s1 !== 4'd0 || b1 !== 32'd0) begin errors++; $display("FAIL done_alu_idle got=%h/%h exp=0/0", s1, b1); end
        do_op(2'b11, 32'd5, 32'd0, r, lat, bc, s1, b1);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_zero got=%0d exp=5", r); end
        checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL remu_zero_timing got=%0d/%0d exp=1/0", lat, bc); end
    endtask

    task automatic test_flush;
        logic [31:0] r, b1; logic [3:0] s1; int lat, bc, dn;
        start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'd5) begin errors++; $display("FAIL flush_result got=%h exp=5", result); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", dn); end
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_beats_start got=%b/%b exp=0/0", busy, done); end
        do_op(2'b00, 32'd3, 32'd4, r, lat, bc, s1, b1);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL mul_after_flush got=%0d exp=12", r); end
    endtask

    task automatic test_start_ignored;
        int lat;
        lat = 0;
        start = 1'b1; op = 2'b00; src_a = 32'h00001234; src_b = 32'h00000010;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin lat = i; break; end
            start = (i == 5); op = 2'b01; src_a = 32'd7; src_b = 32'd9;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        checks++; if (result !== 32'h00012340) begin errors++; $display("FAIL ignore_busy_start got=%h exp=00012340", result); end
        start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_done_start got=%b/%b exp=0/0", busy, done); end
        checks++; if (result !== 32'h00012340) begin errors++; $display("FAIL ignore_done_result got=%h exp=00012340", result); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r, b1; logic [3:0] s1; int lat, bc;
        start = 1'b1; op = 2'b00; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b/%b exp=0/0", busy, done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(2'b01, 32'h80000000, 32'd4, r, lat, bc, s1, b1);
        checks++; if (r !== 32'h00000002) begin errors++; $display("FAIL mulhu_after_reset got=%h exp=00000002", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_after_reset_lat got=%0d exp=33", lat); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_mul;
        test_div;
        test_div_zero;
        test_flush;
        test_start_ignored;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle sequencer that runs unsigned multiply and divide on the shared single-cycle ALU. It drives the ALU's operand and select inputs with ADD (multiply) or SUB (divide) once per cycle. It keeps the shift registers, iteration counter and result locally. It sits beside the execute stage: the pipeline issues a request, holds on `busy`, and takes `result` when `done` pulses.

## Interface
- `XLEN`, 32, operand/result width. The counter width is $clog2(XLEN).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `src_a`  in  XLEN  multiplicand / dividend; sampled with `start`.
- `src_b`  in  XLEN  multiplier / divisor; sampled with `start`.
- `flush`  in  1  synchronous abort.
- `busy`  out  1  high in MUL and DIV states.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  XLEN  registered result; held until the next accepted `start`.
- `alu_a`, `alu_b`  out  XLEN  ALU operands.
- `alu_sel`  out  4  ALU select: 0 = ADD, 1 = SUB.
- `alu_out`  in  XLEN  ALU result, combinational, same cycle.

## Operation
- States are IDLE, MUL, DIV and DONE. Reset enters IDLE with `busy`=0, `done`=0, `result`=0 and all internal registers at 0.
- **IDLE, `start`=1, `flush`=0:** latch `op`, `src_a` and `src_b`, and set counter = XLEN-1.
  - op[1]=0: go to MUL with acc=0, mcand=src_a, mplier=src_b.
  - op[1]=1 and src_b≠0: go to DIV with rem=0, quo=src_a, dvsr=src_b.
  - op[1]=1 and src_b=0: go straight to DONE with result = all-ones (DIVU) or src_a (REMU).
- **MUL (one step per cycle):**
  - ALU drive: `alu_sel`=0, `alu_a`=acc, `alu_b`=mcand.
  - If mplier[0]=1: sum = `alu_out` and carry = (`alu_out` < acc, unsigned). Otherwise sum = acc and carry = 0.
  - Shift right: {acc, mplier} ← {carry, sum, mplier[XLEN-1:1]}.
- **DIV (one restoring step per cycle):**
  - Form r = {rem, quo[XLEN-1]} (XLEN+1 bits). Drive `alu_sel`=1, `alu_a`=r[XLEN-1:0], `alu_b`=dvsr.
  - ge = r[XLEN] | (`alu_out` ≤ r[XLEN-1:0]), i.e. no borrow.
  - rem ← ge ? `alu_out` : r[XLEN-1:0]; quo ← {quo[XLEN-2:0], ge}.
- **Counter:** decrements each MUL/DIV cycle. On the step where counter = 0, the next state is DONE and `result` is loaded:
  - MUL: the low word of the final shifted {acc, mplier}.
  - MULHU: the high word (acc).
  - DIVU: quo. REMU: rem.
  - These are the post-step values.
- **DONE:** `done`=1 for exactly one cycle, then back to IDLE. `start` during DONE is ignored.
- **Idle ALU drive:** in IDLE and DONE, `alu_a`=`alu_b`=0 and `alu_sel`=0.
- **`start` while busy:** ignored, and the operands are not re-sampled.
- **`flush`:** in any state, the next state is IDLE with `done`=0 and `result` unchanged. When `flush` and `start` are both high in IDLE, `flush` wins and the request is dropped.
- **Reset mid-operation:** immediate return to IDLE with all outputs at their reset values. No `done` is produced.

## Timing
- Start accepted at edge E0 → `busy`=1 from E0 through E32 (XLEN steps on edges E1..E32).
- At E32 `busy` falls and `done`=1 during the cycle after E32; `done` falls at E33. Latency is XLEN+1 cycles from the accepting edge to `done`.
- Divide-by-zero: `done`=1 in the cycle after E0, `busy` never rises, latency 1.
- Minimum spacing between accepted starts is XLEN+2 cycles (IDLE must be revisited after DONE).
- The ALU path is combinational within one cycle: the outputs are driven from registers and `alu_out` is consumed at the same edge.
- No outputs are combinational from `start`, `op` or `src_*`.

## Test plan
- MUL and MULHU with 0xFFFFFFFF × 0xFFFFFFFF → MUL result 0x00000001, MULHU result 0xFFFFFFFE. In both cases `done` arrives exactly 33 cycles after start and `busy` is high for 32 cycles.
- DIVU and REMU with 100 / 7 → 14 and 2. Also 0xFFFFFFFF / 0x00000001 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: DIVU 5 / 0 → 0xFFFFFFFF, and REMU 5 / 0 → 5. In both cases `done` arrives 1 cycle after start and `busy` stays 0.
- Flush at cycle 10 of a DIVU → `busy` is 0 next cycle, there is no `done`, and `result` keeps its previous value. A fresh MUL 3 × 4 started afterwards returns 12.
- `start` pulsed with new operands at cycle 5 of a MUL and during DONE → both ignored, and the original result is unchanged.
- `rst_n` asserted mid-MUL → `busy`=0, `done`=0 and `result`=0 immediately. A new MULHU 0x80000000 × 4 after release returns 0x00000002.
